// File: rtl/burst_sync_controller_pkg.sv
`default_nettype none
// burst_sync_controller_pkg: state encoding and shared defaults for the burst controller.
// Rev 1.0
package burst_sync_controller_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int STATE_W       = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GUARD   = 3'd1;
  localparam logic [2:0] ST_SEARCH  = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  function automatic logic is_busy(input state_t st);
    return st != ST_IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_valid_delay.sv
`default_nettype none
// burst_valid_delay: payload-valid shift register with end-of-burst pulse and empty flag.
// Rev 1.0
module burst_valid_delay #(
  parameter int DEPTH = 4
) (
  input  logic in_clock,
  input  logic in_reset,
  input  logic in_valid,
  output logic out_valid,
  output logic out_done,
  output logic out_empty
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  generate
    if (DEPTH > 1) begin : g_chain
      logic done_q;
      logic done_d;

      // Done is computed one stage early so it can be registered alongside the tap.
      always_comb begin
        line_d = {line_q[DEPTH-2:0], in_valid};
        done_d = line_d[DEPTH-1] & ~line_d[DEPTH-2];
      end

      always_ff @(posedge in_clock) begin
        if (in_reset) begin
          done_q <= 1'b0;
        end else begin
          done_q <= done_d;
        end
      end

      assign out_done = done_q;
    end else begin : g_single
      always_comb begin
        line_d = in_valid;
      end

      assign out_done = line_q[0] & ~in_valid;
    end
  endgenerate

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign out_valid = line_q[DEPTH-1];
  assign out_empty = (line_q == '0);

endmodule
`default_nettype wire

// File: rtl/burst_sync_controller.sv
`default_nettype none
// burst_sync_controller: guard / preamble search / payload sequencer for a burst synchronizer.
// Rev 1.0
module burst_sync_controller
  import burst_sync_controller_pkg::*;
#(
  parameter int DATA_ALIGN_DELAY = 4,
  parameter int CNT_W            = CNT_W_DEFAULT
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_burst_start,
  input  logic [CNT_W-1:0] in_guard_cycles,
  input  logic [CNT_W-1:0] in_search_window,
  input  logic [CNT_W-1:0] in_burst_length,
  input  logic [6:0]       in_threshold_cfg,
  input  logic             in_detected,
  output logic             out_sync_enable,
  output logic             out_sync_reset,
  output logic [6:0]       out_threshold,
  output logic             out_burst_valid,
  output logic             out_burst_done,
  output logic             out_miss,
  output logic             out_overlap_err,
  output logic [2:0]       out_state,
  output logic [CNT_W-1:0] out_lock_count,
  output logic [CNT_W-1:0] out_miss_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] guard_q, guard_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [CNT_W-1:0] length_q, length_d;
  logic [6:0]       threshold_q, threshold_d;
  logic [CNT_W-1:0] lock_count_q, lock_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;
  logic             sync_enable_q, sync_enable_d;
  logic             sync_reset_q, sync_reset_d;
  logic             miss_q, miss_d;
  logic             overlap_err_q, overlap_err_d;

  logic             lock_hit;
  logic [CNT_W-1:0] search_limit;
  logic             payload_active;
  logic             line_empty;

  // A zero window still searches for one cycle.
  assign search_limit   = (window_q == '0) ? ONE : window_q;
  assign payload_active = (state_q == ST_PAYLOAD);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    guard_d       = guard_q;
    window_d      = window_q;
    length_d      = length_q;
    threshold_d   = threshold_q;
    lock_hit      = 1'b0;
    miss_d        = 1'b0;
    overlap_err_d = overlap_err_q | (in_burst_start & is_busy(state_q));

    case (state_q)
      ST_IDLE: begin
        if (in_burst_start) begin
          guard_d     = in_guard_cycles;
          window_d    = in_search_window;
          length_d    = in_burst_length;
          threshold_d = in_threshold_cfg;
          cnt_d       = '0;
          state_d     = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cnt_q == guard_q) begin
          cnt_d   = '0;
          state_d = ST_SEARCH;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_SEARCH: begin
        // Detection is checked before expiry so a lock on the last cycle wins.
        if (in_detected) begin
          lock_hit = 1'b1;
          cnt_d    = '0;
          state_d  = (length_q == '0) ? ST_DRAIN : ST_PAYLOAD;
        end else if (cnt_q == search_limit - ONE) begin
          miss_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_PAYLOAD: begin
        if (cnt_q == length_q - ONE) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DRAIN: begin
        if (line_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    lock_count_d  = (lock_hit && !(&lock_count_q)) ? lock_count_q + ONE : lock_count_q;
    miss_count_d  = (miss_d && !(&miss_count_q)) ? miss_count_q + ONE : miss_count_q;
    sync_enable_d = (state_d == ST_SEARCH);
    sync_reset_d  = (state_d == ST_GUARD);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      guard_q       <= '0;
      window_q      <= '0;
      length_q      <= '0;
      threshold_q   <= '0;
      lock_count_q  <= '0;
      miss_count_q  <= '0;
      sync_enable_q <= 1'b0;
      sync_reset_q  <= 1'b1;
      miss_q        <= 1'b0;
      overlap_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      guard_q       <= guard_d;
      window_q      <= window_d;
      length_q      <= length_d;
      threshold_q   <= threshold_d;
      lock_count_q  <= lock_count_d;
      miss_count_q  <= miss_count_d;
      sync_enable_q <= sync_enable_d;
      sync_reset_q  <= sync_reset_d;
      miss_q        <= miss_d;
      overlap_err_q <= overlap_err_d;
    end
  end

  burst_valid_delay #(
    .DEPTH (DATA_ALIGN_DELAY)
  ) u_valid_delay (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_valid  (payload_active),
    .out_valid (out_burst_valid),
    .out_done  (out_burst_done),
    .out_empty (line_empty)
  );

  assign out_sync_enable = sync_enable_q;
  assign out_sync_reset  = sync_reset_q;
  assign out_threshold   = threshold_q;
  assign out_miss        = miss_q;
  assign out_overlap_err = overlap_err_q;
  assign out_state       = state_q;
  assign out_lock_count  = lock_count_q;
  assign out_miss_count  = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_sync_controller.sv
`default_nettype none
// tb_burst_sync_controller: directed checks of the burst controller with hand-derived timing.
// Rev 1.0
module tb_burst_sync_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_burst_start;
  logic [15:0] in_guard_cycles;
  logic [15:0] in_search_window;
  logic [15:0] in_burst_length;
  logic [6:0]  in_threshold_cfg;
  logic        in_detected;
  logic        out_sync_enable;
  logic        out_sync_reset;
  logic [6:0]  out_threshold;
  logic        out_burst_valid;
  logic        out_burst_done;
  logic        out_miss;
  logic        out_overlap_err;
  logic [2:0]  out_state;
  logic [15:0] out_lock_count;
  logic [15:0] out_miss_count;

  logic        s_start;
  logic        s_sync_enable;
  logic        s_sync_reset;
  logic [6:0]  s_threshold;
  logic        s_burst_valid;
  logic        s_burst_done;
  logic        s_miss;
  logic        s_overlap_err;
  logic [2:0]  s_state;
  logic [3:0]  s_lock_count;
  logic [3:0]  s_miss_count;

  always #5 clk = ~clk;

  burst_sync_controller #(
    .DATA_ALIGN_DELAY (4),
    .CNT_W            (16)
  ) u_dut (
    .in_clock         (clk),
    .in_reset         (rst),
    .in_burst_start   (in_burst_start),
    .in_guard_cycles  (in_guard_cycles),
    .in_search_window (in_search_window),
    .in_burst_length  (in_burst_length),
    .in_threshold_cfg (in_threshold_cfg),
    .in_detected      (in_detected),
    .out_sync_enable  (out_sync_enable),
    .out_sync_reset   (out_sync_reset),
    .out_threshold    (out_threshold),
    .out_burst_valid  (out_burst_valid),
    .out_burst_done   (out_burst_done),
    .out_miss         (out_miss),
    .out_overlap_err  (out_overlap_err),
    .out_state        (out_state),
    .out_lock_count   (out_lock_count),
    .out_miss_count   (out_miss_count)
  );

  burst_sync_controller #(
    .DATA_ALIGN_DELAY (4),
    .CNT_W            (4)
  ) u_small (
    .in_clock         (clk),
    .in_reset         (rst),
    .in_burst_start   (s_start),
    .in_guard_cycles  (4'd0),
    .in_search_window (4'd1),
    .in_burst_length  (4'd0),
    .in_threshold_cfg (7'd0),
    .in_detected      (1'b0),
    .out_sync_enable  (s_sync_enable),
    .out_sync_reset   (s_sync_reset),
    .out_threshold    (s_threshold),
    .out_burst_valid  (s_burst_valid),
    .out_burst_done   (s_burst_done),
    .out_miss         (s_miss),
    .out_overlap_err  (s_overlap_err),
    .out_state        (s_state),
    .out_lock_count   (s_lock_count),
    .out_miss_count   (s_miss_count)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [2:0]  st_log   [40];
  logic        srst_log [40];
  logic        en_log   [40];
  logic        val_log  [40];
  logic        done_log [40];
  logic        miss_log [40];
  logic [15:0] lock_log [40];

  int n_val, first_val, n_done, done_k, n_miss, miss_k, n_srst, n_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle k=1 is the first cycle after the start pulse is sampled.
  task automatic run_burst(input int g, input int w, input int len, input int thr,
                           input int det_k, input int dup_k, input int rst_k);
    in_guard_cycles  = g[15:0];
    in_search_window = w[15:0];
    in_burst_length  = len[15:0];
    in_threshold_cfg = thr[6:0];
    in_burst_start   = 1'b1;
    for (int k = 1; k < 40; k++) begin
      tick();
      if (k == 1) begin
        in_guard_cycles  = 16'd0;
        in_search_window = 16'd0;
        in_burst_length  = 16'd0;
        in_threshold_cfg = ~thr[6:0];
      end
      in_burst_start = (k == dup_k);
      in_detected    = (k == det_k);
      rst            = (k == rst_k);
      st_log[k]   = out_state;
      srst_log[k] = out_sync_reset;
      en_log[k]   = out_sync_enable;
      val_log[k]  = out_burst_valid;
      done_log[k] = out_burst_done;
      miss_log[k] = out_miss;
      lock_log[k] = out_lock_count;
    end
    in_burst_start = 1'b0;
    in_detected    = 1'b0;
    rst            = 1'b0;
    n_val = 0; first_val = -1; n_done = 0; done_k = -1;
    n_miss = 0; miss_k = -1; n_srst = 0; n_en = 0;
    for (int k = 1; k < 40; k++) begin
      if (val_log[k]) begin
        n_val++;
        if (first_val < 0) first_val = k;
      end
      if (done_log[k]) begin n_done++; done_k = k; end
      if (miss_log[k]) begin n_miss++; miss_k = k; end
      if (srst_log[k]) n_srst++;
      if (en_log[k])   n_en++;
    end
  endtask

  initial begin
    rst              = 1'b1;
    in_burst_start   = 1'b0;
    in_guard_cycles  = 16'd0;
    in_search_window = 16'd0;
    in_burst_length  = 16'd0;
    in_threshold_cfg = 7'd0;
    in_detected      = 1'b0;
    s_start          = 1'b0;
    repeat (3) tick();

    check("rst_state", out_state, 0);
    check("rst_outs", {out_sync_reset, out_sync_enable, out_burst_valid, out_burst_done,
                       out_miss, out_overlap_err}, 32'b100000);
    check("rst_thr", out_threshold, 0);
    check("rst_cnts", {out_lock_count, out_miss_count}, 0);

    // Nominal burst, started in the first cycle after reset release.
    rst = 1'b0;
    run_burst(3, 8, 10, 'h55, 9, -1, -1);
    check("s1_states", {st_log[1], st_log[5], st_log[9], st_log[10], st_log[19], st_log[20],
                        st_log[24], st_log[25]}, {3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0});
    check("s1_srst_cycles", n_srst, 4);
    check("s1_en_cycles", n_en, 5);
    check("s1_valid_cycles", n_val, 10);
    check("s1_first_valid", first_val, 14);
    check("s1_done", {n_done[7:0], done_k[7:0]}, {8'd1, 8'd23});
    check("s1_lock", lock_log[25], 1);
    check("s1_thr", out_threshold, 'h55);
    check("s1_nomiss", n_miss, 0);

    // Window expiry without detection.
    run_burst(0, 6, 5, 'h11, -1, -1, -1);
    check("s2_miss", {n_miss[7:0], miss_k[7:0]}, {8'd1, 8'd8});
    check("s2_state8", st_log[8], 0);
    check("s2_en_cycles", n_en, 6);
    check("s2_novalid", n_val, 0);
    check("s2_miss_count", out_miss_count, 1);

    // Detection on the final window cycle.
    run_burst(1, 3, 2, 'h22, 5, -1, -1);
    check("s3_nomiss", n_miss, 0);
    check("s3_states", {st_log[2], st_log[5], st_log[6], st_log[8], st_log[12], st_log[13]},
          {3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd0});
    check("s3_valid", {n_val[7:0], first_val[7:0]}, {8'd2, 8'd10});
    check("s3_counts", {out_lock_count, out_miss_count}, {16'd2, 16'd1});

    // Zero guard and zero length.
    run_burst(0, 4, 0, 'h01, 2, -1, -1);
    check("s4_srst_cycles", n_srst, 1);
    check("s4_states", {st_log[1], st_log[2], st_log[3], st_log[4]},
          {3'd1, 3'd2, 3'd4, 3'd0});
    check("s4_novalid", {n_val[7:0], n_done[7:0]}, 0);
    check("s4_lock", out_lock_count, 3);
    check("s4_no_overlap", out_overlap_err, 0);

    // Second start during payload is ignored.
    run_burst(3, 8, 10, 'h33, 9, 12, -1);
    check("s5_valid", {n_val[7:0], first_val[7:0]}, {8'd10, 8'd14});
    check("s5_done", {n_done[7:0], done_k[7:0]}, {8'd1, 8'd23});
    check("s5_state25", st_log[25], 0);
    check("s5_thr", out_threshold, 'h33);
    repeat (3) tick();
    check("s5_overlap_sticky", out_overlap_err, 1);

    // Reset during the third payload cycle.
    run_burst(3, 8, 10, 'h44, 9, -1, 12);
    check("s6_state13", st_log[13], 0);
    check("s6_srst13", srst_log[13], 1);
    check("s6_novalid", {n_val[7:0], n_done[7:0], n_miss[7:0]}, 0);
    check("s6_lock13", lock_log[13], 0);
    check("s6_cnts", {out_lock_count, out_miss_count, 15'd0, out_overlap_err}, 0);

    // Saturation of the narrow miss counter.
    for (int i = 0; i < 17; i++) begin
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      tick();
      tick();
      if (i == 14) check("sat_at_15", s_miss_count, 15);
    end
    check("sat_hold", s_miss_count, 15);
    check("sat_state", s_state, 0);
    check("sat_lock", s_lock_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/burst_sync_controller.md
BURST_SYNC_CONTROLLER -- requirements
Module: burst_sync_controller

Interface
REQ-001 Parameter: DATA_ALIGN_DELAY, default 4, cycles from synchronizer lock to aligned out_data.
REQ-002 Parameter: CNT_W, default 16, width of length/window/guard fields and statistics counters.
REQ-003 in_clock  input  1  single clock for all logic.
REQ-004 in_reset  input  1  synchronous, active-high reset.
REQ-005 in_burst_start  input  1  one-cycle grant pulse marking the start of an upstream burst.
REQ-006 in_guard_cycles  input  CNT_W  guard-time length in cycles, sampled on an accepted start.
REQ-007 in_search_window  input  CNT_W  maximum preamble search cycles, sampled on an accepted start.
REQ-008 in_burst_length  input  CNT_W  payload cycles after lock, sampled on an accepted start.
REQ-009 in_threshold_cfg  input  7  SAD threshold, sampled on an accepted start.
REQ-010 in_detected  input  1  synchronizer detect flag.
REQ-011 out_sync_enable  output  1  drives the synchronizer enable.
REQ-012 out_sync_reset  output  1  drives the synchronizer reset.
REQ-013 out_threshold  output  7  latched threshold to the synchronizer.
REQ-014 out_burst_valid  output  1  aligned payload-valid qualifier for the synchronizer out_data.
REQ-015 out_burst_done  output  1  one-cycle pulse on the last aligned payload cycle.
REQ-016 out_miss  output  1  one-cycle pulse when the search window expires without detection.
REQ-017 out_overlap_err  output  1  sticky flag for a start pulse received while busy.
REQ-018 out_state  output  3  current state encoding.
REQ-019 out_lock_count, out_miss_count  output  CNT_W each  saturating statistics counters.

Function
REQ-020 The controller SHALL implement the states IDLE=0, GUARD=1, SEARCH=2, PAYLOAD=3 and DRAIN=4.
REQ-021 In IDLE, in_burst_start SHALL latch all configuration inputs, and the state SHALL be GUARD on the next cycle.
REQ-022 GUARD SHALL last in_guard_cycles+1 cycles, so guard=0 still gives one cycle, with out_sync_reset=1 and out_sync_enable=0.
REQ-023 SEARCH SHALL assert out_sync_enable=1 and out_sync_reset=0 for at most max(in_search_window,1) cycles.
REQ-024 in_detected=1 in any SEARCH cycle, including the final one, SHALL give PAYLOAD on the next cycle and increment out_lock_count; when detection and expiry coincide, lock SHALL win.
REQ-025 Expiry without detection SHALL pulse out_miss for one cycle, increment out_miss_count and return to IDLE.
REQ-026 PAYLOAD SHALL hold out_sync_enable=0, so the shift is frozen, and SHALL last in_burst_length cycles; length=0 SHALL skip directly to DRAIN.
REQ-027 out_burst_valid SHALL equal (state==PAYLOAD) delayed by exactly DATA_ALIGN_DELAY cycles through a shift register.
REQ-028 DRAIN SHALL persist until the delay line is empty, then return to IDLE.
REQ-029 out_burst_done SHALL pulse in the cycle where out_burst_valid is 1 and its delayed successor is 0.
REQ-030 in_burst_start outside IDLE SHALL be ignored and SHALL set out_overlap_err; in_burst_start in the DRAIN→IDLE transition cycle SHALL also be ignored.
REQ-031 The counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-032 All outputs SHALL be registered; out_threshold SHALL hold its latched value until the next accepted start.

Reset
REQ-033 While in_reset=1, state SHALL be IDLE, and the delay line, counters, out_overlap_err, out_miss, out_burst_done, out_burst_valid and out_sync_enable SHALL be 0.
REQ-034 While in_reset=1, out_sync_reset SHALL be 1 and out_threshold SHALL be 0.
REQ-035 Reset asserted mid-burst SHALL abort immediately, with no done or miss pulse generated.
REQ-036 The first cycle after reset release SHALL accept in_burst_start.

Structure
REQ-037 A shared package SHALL hold the state encoding constants and the CNT_W default, shared with the synchronizer top.
REQ-038 A sub-module, burst_valid_delay (parameterised shift register with an empty flag), SHALL implement REQ-027/028.

Verification
REQ-039 guard=3, window=8, length=10, detect at search cycle 5 -> sync_reset high for 4 cycles, enable high for 5 cycles, burst_valid high for 10 cycles starting 4 cycles after PAYLOAD entry, one done pulse, lock_count=1.
REQ-040 window=6, detect never asserted -> miss pulse 6 cycles after SEARCH entry, miss_count=1, state returns to IDLE, burst_valid never asserted.
REQ-041 Detect on the final window cycle -> lock taken with no miss pulse; guard=0, length=0 -> one GUARD cycle, burst_valid never high, return to IDLE after the drain.
REQ-042 Second start pulse during PAYLOAD -> ignored, out_overlap_err=1 sticky, first burst completes unchanged.
REQ-043 Reset asserted at PAYLOAD cycle 3 -> next cycle IDLE, sync_reset=1, valid=0, counters 0, no done pulse.
REQ-044 Preload out_miss_count to the maximum via 2^CNT_W misses (CNT_W=4 override, 16 misses plus 1) -> count stays at 15.
